mem_access_stage: RTL and testbench

Parametrised memory-access pipeline stage. It sits between the EX/MEM pipeline register and the MEM/WB register, and replaces the single-cycle LW/SW-only memory stage. It adds byte and halfword loads and stores with sign or zero extension, and alignment checking that raises AdEL/AdES. Data memory is reached through a req/ack handshake with arbitrary wait states, a bounded timeout (bus error) and a pipeline stall request.

---
 rtl/mem_access_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: byte/halfword/word loads and stores with
// sign/zero extension, alignment faults (AdEL/AdES), and a req/ack data-memory
// handshake with bounded wait (DBE on timeout) and a pipeline stall request.
module mem_access_stage #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       sdata_i,
    input  logic [31:0]       wdata_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [31:0]       wdata_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [4:0]        exc_o,
    output logic [ADDR_W-1:0] badvaddr_o
);
    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state;
    logic [7:0]        wait_cnt;
    logic              drop;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        wd_q;
    logic              wreg_q;

    logic              is_load, is_store, is_mem, misal;
    logic [3:0]        sel_n;
    logic [31:0]       wdata_n;
    logic              store_q;
    logic [31:0]       shifted;
    logic [15:0]       half;
    logic [31:0]       load_data;

    // Decode the incoming op: class, alignment and store lane placement.
    always_comb begin
        is_load  = (op_i >= OP_LB) && (op_i <= OP_LW);
        is_store = (op_i >= OP_SB) && (op_i <= OP_SW);
        is_mem   = is_load || is_store;
        misal    = (((op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH)) && addr_i[0]) ||
                   (((op_i == OP_LW) || (op_i == OP_SW)) && (addr_i[1:0] != 2'b00));
        sel_n    = 4'b1111;
        wdata_n  = 32'd0;
        case (op_i)
            OP_SB: begin
                sel_n   = 4'b0001 << addr_i[1:0];
                wdata_n = {4{sdata_i[7:0]}};
            end
            OP_SH: begin
                sel_n   = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{sdata_i[15:0]}};
            end
            OP_SW:   wdata_n = sdata_i;
            default: ;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        store_q   = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
        shifted   = mem_rdata >> {addr_q[1:0], 3'b000};
        half      = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'd0, shifted[7:0]};
            OP_LH:   load_data = {{16{half[15]}}, half};
            OP_LHU:  load_data = {16'd0, half};
            default: load_data = mem_rdata;
        endcase
    end

    // Hold upstream while an aligned memory op is being accepted or is on the bus.
    always_comb begin
        stall_o = ((state == IDLE) && in_valid && !flush_i && is_mem && !misal) ||
                  (state == REQ);
    end

    // Stage FSM with registered bus and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            drop       <= 1'b0;
            op_q       <= 4'd0;
            addr_q     <= '0;
            wd_q       <= 5'd0;
            wreg_q     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_sel    <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            out_valid  <= 1'b0;
            wdata_o    <= 32'd0;
            wd_o       <= 5'd0;
            wreg_o     <= 1'b0;
            exc_o      <= 5'd0;
            badvaddr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (in_valid && !flush_i) begin
                        if (!is_mem) begin
                            out_valid  <= 1'b1;
                            wdata_o    <= wdata_i;
                            wd_o       <= wd_i;
                            wreg_o     <= wreg_i;
                            exc_o      <= 5'd0;
                            badvaddr_o <= '0;
                        end else if (misal) begin
                            out_valid  <= 1'b1;
                            wdata_o    <= 32'd0;
                            wd_o       <= wd_i;
                            wreg_o     <= 1'b0;
                            exc_o      <= is_load ? 5'd4 : 5'd5;
                            badvaddr_o <= addr_i;
                        end else begin
                            op_q      <= op_i;
                            addr_q    <= addr_i;
                            wd_q      <= wd_i;
                            wreg_q    <= wreg_i;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_sel   <= sel_n;
                            mem_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
                            mem_wdata <= wdata_n;
                            wait_cnt  <= 8'd0;
                            drop      <= 1'b0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    drop <= drop || flush_i;
                    if (mem_ack) begin
                        // ack beats a same-cycle timeout
                        mem_req    <= 1'b0;
                        out_valid  <= !(drop || flush_i);
                        wdata_o    <= store_q ? 32'd0 : load_data;
                        wd_o       <= wd_q;
                        wreg_o     <= wreg_q && !store_q;
                        exc_o      <= 5'd0;
                        badvaddr_o <= '0;
                        state      <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_req    <= 1'b0;
                        out_valid  <= !(drop || flush_i);
                        wdata_o    <= 32'd0;
                        wd_o       <= wd_q;
                        wreg_o     <= 1'b0;
                        exc_o      <= 5'd7;
                        badvaddr_o <= addr_q;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    drop      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against an arithmetic
// reference model of lane selection, extension, alignment and timeout rules.
module tb_mem_access_stage;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush_i, wreg_i, mem_ack;
    logic [3:0]  op_i;
    logic [31:0] addr_i, sdata_i, wdata_i, mem_rdata;
    logic [4:0]  wd_i;
    logic        stall_o, mem_req, mem_we, out_valid, wreg_o;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata, wdata_o, badvaddr_o;
    logic [4:0]  wd_o, exc_o;

    int checks = 0;
    int failures = 0;

    mem_access_stage #(.ADDR_W(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op_i(op_i), .addr_i(addr_i),
        .sdata_i(sdata_i), .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .exc_o(exc_o),
        .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Access size in bytes (0 for non-memory ops).
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        longint sz, mask, v;
        sz   = op_size(op);
        mask = (longint'(1) << (8 * sz)) - 1;
        v    = (longint'(rd) >> (8 * (a % 4))) & mask;
        if ((op == 4'd1 || op == 4'd3) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [3:0] op, input logic [31:0] sd);
        longint sz, mask, v;
        sz   = op_size(op);
        mask = (longint'(1) << (8 * sz)) - 1;
        v    = (longint'(sd) & mask) * (sz == 1 ? 64'h01010101 : sz == 2 ? 64'h00010001 : 64'd1);
        return v[31:0];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_req"},   32'(mem_req), 32'd0);
        check({tag, "_we"},    32'(mem_we), 32'd0);
        check({tag, "_sel"},   32'(mem_sel), 32'd0);
        check({tag, "_addr"},  mem_addr, 32'd0);
        check({tag, "_wdat"},  mem_wdata, 32'd0);
        check({tag, "_ov"},    32'(out_valid), 32'd0);
        check({tag, "_wdo"},   wdata_o, 32'd0);
        check({tag, "_wd"},    32'(wd_o), 32'd0);
        check({tag, "_wreg"},  32'(wreg_o), 32'd0);
        check({tag, "_exc"},   32'(exc_o), 32'd0);
        check({tag, "_bva"},   badvaddr_o, 32'd0);
    endtask

    // One instruction end to end; waits >= MW means no ack ever; fl_req = REQ cycle to flush in (-1 none).
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int waits, input bit fl_idle, input int fl_req);
        int          sz, last;
        bit          is_mem, is_st, misal, dropped, tmo;
        logic [31:0] alu;
        logic [4:0]  rdst;
        logic        we;
        alu   = $urandom;
        rdst  = 5'($urandom);
        we    = 1'($urandom);
        sz    = op_size(op);
        is_mem = sz != 0;
        is_st  = op >= 4'd6 && op <= 4'd8;
        misal  = is_mem && (a % sz) != 0;
        last   = 0;
        @(negedge clk);
        in_valid = 1'b1; op_i = op; addr_i = a; sdata_i = sd; wdata_i = alu;
        wd_i = rdst; wreg_i = we; flush_i = fl_idle;
        #1 check("stall_idle", 32'(stall_o), 32'(is_mem && !misal && !fl_idle));
        if (fl_idle || !is_mem || misal) begin
            @(negedge clk);
            in_valid = 1'b0; flush_i = 1'b0;
            check("ov_fast", 32'(out_valid), 32'(!fl_idle));
            check("req_fast", 32'(mem_req), 32'd0);
            if (!fl_idle) begin
                check("exc_fast", 32'(exc_o), !is_mem ? 32'd0 : (is_st ? 32'd5 : 32'd4));
                check("bva_fast", badvaddr_o, is_mem ? a : 32'd0);
                check("wreg_fast", 32'(wreg_o), is_mem ? 32'd0 : 32'(we));
                check("wd_fast", 32'(wd_o), 32'(rdst));
                if (!is_mem) check("wdata_none", wdata_o, alu);
            end
            @(negedge clk);
            check("ov_pulse_fast", 32'(out_valid), 32'd0);
            return;
        end
        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            flush_i = (i == fl_req);
            check("req_hold", 32'(mem_req), 32'd1);
            check("addr_hold", mem_addr, a & 32'hFFFF_FFFC);
            check("sel_hold", 32'(mem_sel), is_st ? (((32'd1 << sz) - 1) << (a % 4)) : 32'hF);
            check("we_hold", 32'(mem_we), 32'(is_st));
            if (is_st) check("wdata_hold", mem_wdata, ref_store(op, sd));
            check("stall_req", 32'(stall_o), 32'd1);
            check("ov_req", 32'(out_valid), 32'd0);
            mem_ack   = (i == waits);
            mem_rdata = (i == waits) ? rd : $urandom;
            last = i;
            if (i == waits) break;
        end
        dropped = fl_req >= 0 && fl_req <= last;
        tmo     = waits >= MW;
        @(negedge clk);
        mem_ack = 1'b0; flush_i = 1'b0; mem_rdata = $urandom;
        check("ov_resp", 32'(out_valid), 32'(!dropped));
        check("stall_resp", 32'(stall_o), 32'd0);
        check("req_resp", 32'(mem_req), 32'd0);
        if (!dropped) begin
            check("exc_resp", 32'(exc_o), tmo ? 32'd7 : 32'd0);
            check("bva_resp", badvaddr_o, tmo ? a : 32'd0);
            check("wreg_resp", 32'(wreg_o), (tmo || is_st) ? 32'd0 : 32'(we));
            check("wd_resp", 32'(wd_o), 32'(rdst));
            if (!tmo && !is_st) check("load_data", wdata_o, ref_load(op, a, rd));
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("ov_pulse", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush_i = 1'b0; op_i = 4'd0; addr_i = 32'd0;
        sdata_i = 32'd0; wdata_i = 32'd0; wd_i = 5'd0; wreg_i = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;

        // reset in the middle of a bus cycle
        @(negedge clk);
        in_valid = 1'b1; op_i = 4'd5; addr_i = 32'h400; wd_i = 5'd3; wreg_i = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("req_before_rst", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_mid");
        do_op(4'd5, 32'h400, 32'd0, 32'h1234_5678, 0, 1'b0, -1);

        // directed cases
        do_op(4'd1, 32'h103, 32'd0, 32'h80FF_1234, 3, 1'b0, -1);
        do_op(4'd4, 32'h202, 32'd0, 32'h8001_0000, 1, 1'b0, -1);
        do_op(4'd7, 32'h302, 32'hAAAA_BEEF, 32'd0, 2, 1'b0, -1);
        do_op(4'd5, 32'h101, 32'd0, 32'd0, 0, 1'b0, -1);
        do_op(4'd8, 32'h102, 32'h1, 32'd0, 0, 1'b0, -1);
        do_op(4'd5, 32'h500, 32'd0, 32'd0, 10, 1'b0, -1);
        do_op(4'd2, 32'h601, 32'd0, 32'hCAFE_F00D, MW - 1, 1'b0, -1);
        do_op(4'd5, 32'h700, 32'd0, 32'h1111_2222, 2, 1'b0, 0);
        do_op(4'd0, 32'h0, 32'd0, 32'd0, 0, 1'b1, -1);
        do_op(4'd6, 32'h801, 32'h0000_00A5, 32'd0, 0, 1'b0, -1);
        do_op(4'd12, 32'h3, 32'd0, 32'd0, 0, 1'b0, -1);

        // random mix
        for (int n = 0; n < 150; n++) begin
            do_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                  int'($urandom_range(0, MW + 1)),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MW - 1)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
